// File: rtl/demosaic_pipe_ctrl.sv
// demosaic_pipe_ctrl: frame sequencer for the 3x3 demosaic datapath.
// Owns the shared shift enable of the window/interpolation chain, injects
// zero-padded flush shifts after the last pixel, and tags each output pixel
// with its coordinates, Bayer phase and border flags.
module demosaic_pipe_ctrl #(
    parameter int unsigned IMG_W    = 640,
    parameter int unsigned IMG_H    = 480,
    parameter int unsigned PIPE_LAT = 2
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic                     start,
    input  logic                     s_valid,
    output logic                     s_ready,
    output logic                     fill_sel,
    output logic                     shift_en,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [$clog2(IMG_W)-1:0] out_col,
    output logic [$clog2(IMG_H)-1:0] out_row,
    output logic [1:0]               bayer_phase,
    output logic [3:0]               border,
    output logic                     busy,
    output logic                     frame_done
);

    localparam int unsigned N    = IMG_W * IMG_H;
    localparam int unsigned L    = IMG_W + 1 + PIPE_LAT;
    localparam int unsigned ScW  = $clog2(N + L + 1);
    localparam int unsigned ColW = $clog2(IMG_W);
    localparam int unsigned RowW = $clog2(IMG_H);

    localparam logic [ScW-1:0]  LastIn  = ScW'(N - 1);
    localparam logic [ScW-1:0]  LastSh  = ScW'(N + L - 1);
    localparam logic [ScW-1:0]  ValThr  = ScW'(L);
    localparam logic [ColW-1:0] LastCol = ColW'(IMG_W - 1);
    localparam logic [RowW-1:0] LastRow = RowW'(IMG_H - 1);

    typedef enum logic [1:0] {StIdle, StRun, StFlush, StDrain} state_e;

    state_e          state_q, state_d;
    logic [ScW-1:0]  sc_q, sc_d;
    logic            m_valid_q, m_valid_d;
    logic [ColW-1:0] col_q, col_d;
    logic [RowW-1:0] row_q, row_d;
    logic            done_q, done_d;
    logic            clear;
    logic            stall;
    logic            out_hs;

    assign stall  = m_valid_q && !m_ready;
    assign out_hs = m_valid_q && m_ready;

    // Next state and shift/handshake control.
    always_comb begin
        state_d  = state_q;
        s_ready  = 1'b0;
        shift_en = 1'b0;
        fill_sel = 1'b0;
        done_d   = 1'b0;
        clear    = 1'b0;
        unique case (state_q)
            StIdle: begin
                // A start landing on the frame_done cycle is dropped.
                if (start && !done_q) begin
                    clear   = 1'b1;
                    state_d = StRun;
                end
            end
            StRun: begin
                s_ready  = !stall;
                shift_en = s_valid && !stall;
                if (shift_en && (sc_q == LastIn)) begin
                    state_d = StFlush;
                end
            end
            StFlush: begin
                fill_sel = 1'b1;
                shift_en = !stall;
                if (shift_en && (sc_q == LastSh)) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (!m_valid_q || m_ready) begin
                    done_d  = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Shift counter, output-valid tracking and output coordinate advance.
    always_comb begin
        sc_d      = sc_q;
        m_valid_d = m_valid_q && !m_ready;
        col_d     = col_q;
        row_d     = row_q;
        if (shift_en) begin
            sc_d      = sc_q + ScW'(1);
            m_valid_d = (sc_q >= ValThr);
        end
        if (clear) begin
            sc_d = '0;
        end
        if (out_hs) begin
            if (col_q == LastCol) begin
                col_d = '0;
                row_d = (row_q == LastRow) ? '0 : row_q + RowW'(1);
            end else begin
                col_d = col_q + ColW'(1);
            end
        end
        if (clear) begin
            col_d = '0;
            row_d = '0;
        end
    end

    // State registers, cleared together with the datapath on RESET.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q   <= StIdle;
            sc_q      <= '0;
            m_valid_q <= 1'b0;
            col_q     <= '0;
            row_q     <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            sc_q      <= sc_d;
            m_valid_q <= m_valid_d;
            col_q     <= col_d;
            row_q     <= row_d;
            done_q    <= done_d;
        end
    end

    assign m_valid     = m_valid_q;
    assign out_col     = col_q;
    assign out_row     = row_q;
    assign bayer_phase = {row_q[0], col_q[0]};
    assign border      = {row_q == '0, row_q == LastRow, col_q == '0, col_q == LastCol};
    assign busy        = (state_q != StIdle);
    assign frame_done  = done_q;

endmodule

// File: tb/tb_demosaic_pipe_ctrl.sv
// Testbench for demosaic_pipe_ctrl: a behavioural shift-register datapath
// driven by shift_en/fill_sel, a scoreboard fed on every accepted pixel and
// a monitor comparing every output handshake against it.
module tb_demosaic_pipe_ctrl;

    localparam int W = 4;
    localparam int H = 3;
    localparam int P = 2;
    localparam int N = W * H;
    localparam int L = W + 1 + P;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       start;
    logic       s_valid;
    logic       s_ready;
    logic       fill_sel;
    logic       shift_en;
    logic       m_valid;
    logic       m_ready;
    logic [1:0] out_col;
    logic [1:0] out_row;
    logic [1:0] bayer_phase;
    logic [3:0] border;
    logic       busy;
    logic       frame_done;

    demosaic_pipe_ctrl #(.IMG_W(W), .IMG_H(H), .PIPE_LAT(P)) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .start      (start),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .fill_sel   (fill_sel),
        .shift_en   (shift_en),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .out_col    (out_col),
        .out_row    (out_row),
        .bayer_phase(bayer_phase),
        .border     (border),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 CLK = ~CLK;

    // Input pixel value is its raster index within the frame.
    int          pix_idx;
    logic [19:0] s_data;
    logic [19:0] pipe [0:L];
    logic [19:0] m_data;
    assign s_data = pix_idx[19:0];
    assign m_data = pipe[L];

    // Index of the next pixel to be accepted.
    always @(posedge CLK or negedge RESET) begin
        if (!RESET) pix_idx <= 0;
        else if (frame_done) pix_idx <= 0;
        else if (s_valid && s_ready) pix_idx <= pix_idx + 1;
    end

    // Datapath stand-in: L+1 registers clocked by shift_en.
    always @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            for (int k = 0; k <= L; k++) pipe[k] <= '0;
        end else if (shift_en) begin
            pipe[0] <= fill_sel ? 20'd0 : s_data;
            for (int k = 1; k <= L; k++) pipe[k] <= pipe[k-1];
        end
    end

    typedef struct {
        logic [19:0] data;
        int          col;
        int          row;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   shifts, out_cnt, busy_cyc, last_hs, idle_chk;
    bit   seen_v, prev_stall;
    bit   cont_mode = 0;
    logic [23:0] saved;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: scoreboard push/pop plus per-cycle protocol checks.
    always @(negedge CLK) begin
        exp_t e;
        logic [3:0] eb;
        cyc++;
        if (!RESET) begin
            chk("reset_state",
                {s_ready, fill_sel, shift_en, m_valid, busy, frame_done,
                 out_col, out_row, bayer_phase, border},
                {6'b0, 2'd0, 2'd0, 2'd0, 4'b1010});
            exp_q.delete();
            shifts = 0; out_cnt = 0; busy_cyc = 0; last_hs = 0; idle_chk = 0;
            seen_v = 0; prev_stall = 0;
        end else begin
            if (frame_done) begin
                chk("frame_outputs", out_cnt, N);
                chk("frame_shifts", shifts, N + L);
                chk("done_after_last_hs", cyc - last_hs, 1);
                chk("busy_at_done", busy, 0);
                chk("coords_wrapped", {out_col, out_row}, 0);
                chk("sb_drained", exp_q.size(), 0);
                if (cont_mode) chk("frame_cycles", busy_cyc, N + L + 1);
                shifts = 0; out_cnt = 0; busy_cyc = 0; seen_v = 0;
                idle_chk = 3;
            end else if (idle_chk > 0) begin
                chk("idle_after_done", {busy, frame_done}, 0);
                idle_chk--;
            end
            if (busy) busy_cyc++;
            if (m_valid && !seen_v) begin
                seen_v = 1;
                chk("first_valid_shift", shifts, L + 1);
            end
            if (prev_stall) begin
                chk("stall_hold_valid", m_valid, 1);
                chk("stall_hold_data", {m_data, out_col, out_row}, saved);
            end
            prev_stall = m_valid && !m_ready;
            if (prev_stall) begin
                chk("stall_shift_en", shift_en, 0);
                chk("stall_s_ready", s_ready, 0);
                saved = {m_data, out_col, out_row};
            end
            if (busy && !fill_sel && !s_valid) chk("no_shift_without_valid", shift_en, 0);
            if (shift_en) shifts++;
            if (s_valid && s_ready) begin
                e.data = s_data;
                e.col  = pix_idx % W;
                e.row  = pix_idx / W;
                exp_q.push_back(e);
            end
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    chk("scoreboard_empty", exp_q.size(), 1);
                end else begin
                    e = exp_q.pop_front();
                    eb = {e.row == 0, e.row == H - 1, e.col == 0, e.col == W - 1};
                    chk("out_data", m_data, e.data);
                    chk("out_col", out_col, e.col);
                    chk("out_row", out_row, e.row);
                    chk("bayer_phase", bayer_phase, {e.row[0], e.col[0]});
                    chk("border", border, eb);
                end
                if (out_cnt == 0) chk("tag_out0", {bayer_phase, border}, {2'd0, 4'b1010});
                if (out_cnt == 5) chk("tag_out5", {bayer_phase, border}, {2'd3, 4'b0000});
                if (out_cnt == 11) chk("tag_out11", border, 4'b0101);
                out_cnt++;
                last_hs = cyc;
            end
        end
    end

    // mode 0: continuous, 1: stall at output 4 + ignored starts,
    // 2: toggled s_valid, 3: reset during flush.
    task automatic run_frame(input int mode);
        int n = 0;
        int hold = 0;
        int fcnt = 0;
        bit stalled = 0;
        cont_mode = (mode == 0);
        s_valid = 1'b1;
        m_ready = 1'b1;
        start = 1'b1;
        @(posedge CLK); #1;
        start = 1'b0;
        while (!frame_done) begin
            if (mode == 1) begin
                start = (n == 3);
                if (hold > 0) begin
                    hold--;
                    if (hold == 0) m_ready = 1'b1;
                end else if (m_valid && out_cnt == 4 && !stalled) begin
                    m_ready = 1'b0;
                    hold = 3;
                    stalled = 1;
                end
            end
            if (mode == 2) s_valid = (n % 2) == 0;
            if (mode == 3) begin
                if (fill_sel) fcnt++;
                if (fcnt == 3) begin
                    RESET = 1'b0;
                    @(posedge CLK); #1;
                    RESET = 1'b1;
                    break;
                end
            end
            @(posedge CLK); #1;
            n++;
            if (n > 500) begin
                $display("FAIL frame_timeout: got no frame_done after %0d cycles", n);
                $fatal(1);
            end
        end
        if (mode == 1) begin
            start = 1'b1;
            @(posedge CLK); #1;
            start = 1'b0;
        end
        s_valid = 1'b1;
        m_ready = 1'b1;
        repeat (5) @(posedge CLK);
        #1;
    endtask

    initial begin
        RESET = 1'b0;
        start = 1'b0;
        s_valid = 1'b0;
        m_ready = 1'b1;
        repeat (2) @(posedge CLK);
        #1 RESET = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        run_frame(0);
        run_frame(1);
        run_frame(2);
        run_frame(3);
        run_frame(0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
